// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Definitions shared by the PWM generator and the PWM duty decoder:
//   PWM_STEPS : number of duty steps (10 % each), so duty runs 0..PWM_STEPS
//   DUTY_W    : width of a duty value in steps (holds 0..10)
//   state_e   : measurement FSM state encoding used by the decoder
// -----------------------------------------------------------------------------
package pwm_pkg;

    localparam int PWM_STEPS = 10;
    localparam int DUTY_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // waiting for the first rising edge
        ST_HIGH  = 2'd1,  // input high, counting high time
        ST_LOW   = 2'd2,  // input low, next rise closes a period
        ST_STUCK = 2'd3   // no edge for a full counter range
    } state_e;

endpackage

// File: rtl/pwm_duty_decoder_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder_if
// Signal bundle between a PWM source / reader and the duty decoder.
//   pwm_in       : raw PWM input (asynchronous to clk)
//   duty_tenths  : last decoded duty, 0..10 in 10 % steps
//   high_cnt     : last measured high time, clk cycles
//   period_cnt   : last measured period, clk cycles
//   meas_valid   : one-cycle pulse when the three values above update
//   locked       : a periodic input is currently being decoded
//   stuck        : input static; its level is given by duty_tenths (0 or 10)
// Modports: master = the side driving pwm_in; slave = the decoder.
// -----------------------------------------------------------------------------
interface pwm_duty_decoder_if #(
    parameter int CNT_W = 16
) ();
    import pwm_pkg::*;

    logic              pwm_in;
    logic [DUTY_W-1:0] duty_tenths;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              meas_valid;
    logic              locked;
    logic              stuck;

    modport master (
        output pwm_in,
        input  duty_tenths, high_cnt, period_cnt, meas_valid, locked, stuck
    );

    modport slave (
        input  pwm_in,
        output duty_tenths, high_cnt, period_cnt, meas_valid, locked, stuck
    );

endinterface

// File: rtl/pwm_div_seq.sv
// -----------------------------------------------------------------------------
// pwm_div_seq
// Sequential restoring divider producing a 4-bit quotient in 4 iterations.
// The first iteration is done on the start cycle itself, the next two in the
// following cycles, and the last one combinationally in the done cycle, so
// q is valid while done is high (start at cycle S -> done at S+3).
// The caller guarantees num < 16*den, so the quotient fits 4 bits.
//   clk, rst : clock, asynchronous active-high reset
//   start    : 1-cycle pulse, num/den sampled in that cycle
//   abort    : drop any divide in progress
//   num, den : dividend (CNT_W+4 bits), divisor (CNT_W bits, non-zero)
//   busy     : iterations after the start cycle are in progress
//   done     : 1-cycle pulse, q valid
//   q        : quotient
// -----------------------------------------------------------------------------
module pwm_div_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W+3:0] num,
    input  logic [CNT_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [3:0]       q
);

    localparam int NW = CNT_W + 4;

    logic [NW-1:0] r_rem;     // running remainder
    logic [NW-1:0] r_dsh;     // divisor aligned to the next quotient bit
    logic [2:0]    r_q;       // quotient bits already decided, MSB first
    logic [1:0]    r_cnt;     // iterations completed
    logic          r_busy;

    logic [NW-1:0] w_rem_in;
    logic [NW-1:0] w_dsh_in;
    logic [NW-1:0] w_rem_nx;
    logic          w_bit;

    // One restoring step; on start it works straight from the inputs with the
    // divisor aligned to quotient bit 3.
    always_comb begin
        w_rem_in = start ? num : r_rem;
        w_dsh_in = start ? {1'b0, den, 3'b000} : r_dsh;
        w_bit    = (w_rem_in >= w_dsh_in);
        w_rem_nx = w_bit ? (w_rem_in - w_dsh_in) : w_rem_in;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_dsh  <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
        end else if (start) begin
            r_rem  <= w_rem_nx;
            r_dsh  <= w_dsh_in >> 1;
            r_q    <= {2'b00, w_bit};
            r_cnt  <= 2'd1;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_rem  <= w_rem_nx;
            r_dsh  <= r_dsh >> 1;
            r_q    <= {r_q[1:0], w_bit};
            r_cnt  <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == 2'd3);
    assign q    = {r_q, w_bit};

endmodule

// File: rtl/pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// pwm_duty_decoder
// Measures the high time and period of an incoming PWM waveform and reports
// the duty cycle rounded to 10 % steps. An input with no rising edge for a
// full counter range is flagged as stuck at its current level.
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   dec    : pwm_duty_decoder_if slave (pwm_in in; duty_tenths, high_cnt,
//            period_cnt, meas_valid, locked, stuck out, all registered)
// A rise closing a period at cycle T gives meas_valid at T+5 (synced time).
// -----------------------------------------------------------------------------
module pwm_duty_decoder
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pwm_duty_decoder_if.slave    dec
);

    localparam int               NW      = CNT_W + 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchroniser and edge detect
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    // Counters and FSM
    logic [CNT_W-1:0] r_per_ctr;
    logic [CNT_W-1:0] r_hi_ctr;
    state_e           r_state;
    state_e           w_state_nx;
    logic             w_meas;
    logic             w_timeout;

    // Divider hand-off
    logic [NW-1:0]    w_num;
    logic [NW-1:0]    r_num;
    logic [CNT_W-1:0] r_den;
    logic [CNT_W-1:0] r_hi_lat;
    logic             r_start;
    logic             w_busy;
    logic             w_done;
    logic [3:0]       w_q;
    logic             w_div_busy;
    logic             w_accept;

    // Output registers
    logic [DUTY_W-1:0] r_duty;
    logic [CNT_W-1:0]  r_high;
    logic [CNT_W-1:0]  r_period;
    logic              r_meas_valid;
    logic              r_locked;
    logic              r_stuck;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    assign w_fall = ~w_s & r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], dec.pwm_in};
            r_prev <= w_s;
        end
    end

    // Period counts every cycle since the last rise; high counts only while
    // the synced input is high. Both restart at 1 on a rise and saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_ctr <= '0;
            r_hi_ctr  <= '0;
        end else if (w_rise) begin
            r_per_ctr <= CNT_W'(1);
            r_hi_ctr  <= CNT_W'(1);
        end else begin
            if (r_per_ctr != CNT_MAX) begin
                r_per_ctr <= r_per_ctr + CNT_W'(1);
            end
            if (w_s && (r_hi_ctr != CNT_MAX)) begin
                r_hi_ctr <= r_hi_ctr + CNT_W'(1);
            end
        end
    end

    // A rise always wins over a coincident timeout.
    assign w_timeout = (r_per_ctr == CNT_MAX) && !w_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_meas     = 1'b0;
        if (w_rise) begin
            w_state_nx = ST_HIGH;
            w_meas     = (r_state == ST_LOW);
        end else if (w_timeout) begin
            w_state_nx = ST_STUCK;
        end else begin
            case (r_state)
                ST_HIGH: if (w_fall) w_state_nx = ST_LOW;
                default: w_state_nx = r_state;
            endcase
        end
    end

    // Rounded duty: (10*high + period/2) / period. Counters hold the values
    // of the period just closed in the rise cycle, before their reload.
    assign w_num = ({4'b0000, r_hi_ctr} << 3) + ({4'b0000, r_hi_ctr} << 1)
                 + {5'b00000, r_per_ctr[CNT_W-1:1]};

    // A measurement arriving while the previous one is still dividing is
    // dropped rather than queued.
    assign w_div_busy = r_start | w_busy;
    assign w_accept   = w_meas & ~w_div_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num    <= '0;
            r_den    <= '0;
            r_hi_lat <= '0;
            r_start  <= 1'b0;
        end else begin
            r_start <= w_accept;
            if (w_accept) begin
                r_num    <= w_num;
                r_den    <= r_per_ctr;
                r_hi_lat <= r_hi_ctr;
            end
        end
    end

    pwm_div_seq #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (r_start),
        .abort (w_timeout),
        .num   (r_num),
        .den   (r_den),
        .busy  (w_busy),
        .done  (w_done),
        .q     (w_q)
    );

    // Timeout overrides a divide finishing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty       <= '0;
            r_high       <= '0;
            r_period     <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_stuck      <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            if (w_timeout) begin
                r_locked <= 1'b0;
                r_stuck  <= 1'b1;
                r_duty   <= w_s ? DUTY_W'(PWM_STEPS) : '0;
            end else if (w_done) begin
                r_duty       <= w_q;
                r_high       <= r_hi_lat;
                r_period     <= r_den;
                r_meas_valid <= 1'b1;
                r_locked     <= 1'b1;
                r_stuck      <= 1'b0;
            end
        end
    end

    assign dec.duty_tenths = r_duty;
    assign dec.high_cnt    = r_high;
    assign dec.period_cnt  = r_period;
    assign dec.meas_valid  = r_meas_valid;
    assign dec.locked      = r_locked;
    assign dec.stuck       = r_stuck;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_decoder
// Directed bench for pwm_duty_decoder (CNT_W = 8, SYNC_STAGES = 2).
// pwm_in is driven 1 time unit after a rising clock edge; outputs are sampled
// on the falling edge. With that timing a drive after clock edge k shows up
// as a synced rise two edges later, so meas_valid is seen at cycle k+7.
// -----------------------------------------------------------------------------
module tb_pwm_duty_decoder;

    localparam int CNT_W = 8;
    localparam int SYNC  = 2;
    localparam int LAT   = SYNC + 5;   // pin drive -> meas_valid, in cycles

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_duty_decoder_if #(.CNT_W(CNT_W)) dec ();

    pwm_duty_decoder #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .dec (dec)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Log of every meas_valid pulse, and of every rising edge driven on pwm_in
    int mq_duty[$];
    int mq_high[$];
    int mq_per[$];
    int mq_cyc[$];
    int rise_q[$];

    always @(negedge clk) begin
        if (dec.meas_valid === 1'b1) begin
            mq_duty.push_back(int'(dec.duty_tenths));
            mq_high.push_back(int'(dec.high_cnt));
            mq_per.push_back(int'(dec.period_cnt));
            mq_cyc.push_back(cyc);
        end
    end

    // Hand-computed expectations
    int exp_a_duty[7] = '{5, 5, 5, 7, 7, 2, 2};
    int exp_a_high[7] = '{5, 5, 5, 7, 7, 2, 2};
    int exp_f_duty[4] = '{2, 2, 1, 1};
    int exp_f_high[4] = '{3, 3, 2, 2};

    task automatic check(input string tag, input int actual, input int expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clear_log();
        mq_duty.delete();
        mq_high.delete();
        mq_per.delete();
        mq_cyc.delete();
    endtask

    task automatic drive(input logic level);
        @(posedge clk);
        #1;
        dec.pwm_in = level;
    endtask

    // nper periods of `period` cycles, high for the first `high` cycles.
    // Caller makes sure pwm_in is low beforehand so each period starts on a rise.
    task automatic gen(input int period, input int high, input int nper);
        for (int p = 0; p < nper; p++) begin
            for (int c = 0; c < period; c++) begin
                drive(c < high);
                if (c == 0) rise_q.push_back(cyc);
            end
        end
    endtask

    // Advance to the falling edge after clock edge `target`.
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_entry(input string tag, input int idx, input int e_duty,
                               input int e_high, input int e_per, input int e_cyc);
        if (idx < mq_duty.size()) begin
            check($sformatf("%s_duty[%0d]", tag, idx), mq_duty[idx], e_duty);
            check($sformatf("%s_high[%0d]", tag, idx), mq_high[idx], e_high);
            check($sformatf("%s_period[%0d]", tag, idx), mq_per[idx], e_per);
            check($sformatf("%s_latency[%0d]", tag, idx), mq_cyc[idx], e_cyc);
        end else begin
            check($sformatf("%s_present[%0d]", tag, idx), mq_duty.size(), idx + 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"},   int'(dec.duty_tenths), 0);
        check({tag, "_high"},   int'(dec.high_cnt), 0);
        check({tag, "_period"}, int'(dec.period_cnt), 0);
        check({tag, "_mvalid"}, int'(dec.meas_valid), 0);
        check({tag, "_locked"}, int'(dec.locked), 0);
        check({tag, "_stuck"},  int'(dec.stuck), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        dec.pwm_in = 1'b0;
        rst        = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) drive(1'b0);

        // Duty 5 locks after the second rise, then steps to 7 and to 2
        rise_q.delete();
        clear_log();
        gen(10, 5, 3);
        gen(10, 7, 2);
        gen(10, 2, 3);
        wait_cyc(rise_q[7] + 20);
        check("step_count", mq_duty.size(), 7);
        for (int i = 0; i < 7; i++) begin
            check_entry("step", i, exp_a_duty[i], exp_a_high[i], 10, rise_q[i + 1] + LAT);
        end
        check("step_locked", int'(dec.locked), 1);
        check("step_stuck", int'(dec.stuck), 0);

        // Input held low: timeout exactly 255 synced cycles after the last rise
        k = rise_q[7];
        wait_cyc(k + 257);
        check("low_pre_stuck", int'(dec.stuck), 0);
        check("low_pre_locked", int'(dec.locked), 1);
        wait_cyc(k + 258);
        check("low_stuck", int'(dec.stuck), 1);
        check("low_locked", int'(dec.locked), 0);
        check("low_duty", int'(dec.duty_tenths), 0);
        check("low_high_hold", int'(dec.high_cnt), 2);
        check("low_period_hold", int'(dec.period_cnt), 10);

        // Input held high: the rise leaves STUCK without a measurement
        clear_log();
        drive(1'b1);
        k = cyc;
        wait_cyc(k + 257);
        check("high_pre_duty", int'(dec.duty_tenths), 0);
        wait_cyc(k + 258);
        check("high_duty", int'(dec.duty_tenths), 10);
        check("high_stuck", int'(dec.stuck), 1);
        check("high_locked", int'(dec.locked), 0);
        check("high_no_meas", mq_duty.size(), 0);

        // Period 3, high 1: divider still busy on every other rise
        repeat (5) drive(1'b0);
        rise_q.delete();
        clear_log();
        gen(3, 1, 9);
        wait_cyc(cyc + 12);
        check("ovr_count", mq_duty.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check_entry("ovr", j, 3, 1, 3, rise_q[2 * j + 1] + LAT);
        end
        check("ovr_locked", int'(dec.locked), 1);
        check("ovr_stuck", int'(dec.stuck), 0);

        // Reset two synced cycles after a measurement-closing rise
        drive(1'b1);
        k = cyc;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_locked", int'(dec.locked), 1);
        rst = 1'b1;
        clear_log();
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        dec.pwm_in = 1'b0;
        rst        = 1'b0;
        repeat (6) drive(1'b0);
        check("midrst_no_meas", mq_duty.size(), 0);
        check("midrst_duty_after", int'(dec.duty_tenths), 0);

        // Period 20: high 3 rounds 1.5 up to 2, high 2 gives 1
        rise_q.delete();
        gen(20, 3, 2);
        gen(20, 2, 3);
        wait_cyc(rise_q[4] + 20);
        check("r20_count", mq_duty.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_entry("r20", i, exp_f_duty[i], exp_f_high[i], 20, rise_q[i + 1] + LAT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
